// File: rtl/cache_arbiter.sv
// Arbitrates the shared L2 port between the L1 I-cache and D-cache, one line transaction at a time.
// Ties alternate between the two sides; the L2 request is registered and the response is routed back.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state;
  logic   last_d;
  logic   d_req, i_req, grant_d, grant_i;

  // D wins unless I is also asking and D was the previous winner
  always_comb begin
    d_req   = d_mem_read | d_mem_write;
    i_req   = i_mem_read;
    grant_d = d_req & (~i_req | ~last_d);
    grant_i = i_req & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            last_d     <= 1'b1;
            l2_address <= d_mem_address;
            l2_wdata   <= d_mem_wdata;
            l2_write   <= d_mem_write;
            l2_read    <= ~d_mem_write;
          end else if (grant_i) begin
            state      <= SERVE_I;
            last_d     <= 1'b0;
            l2_address <= i_mem_address;
            l2_read    <= 1'b1;
            l2_write   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    i_mem_resp  = (state == SERVE_I) & l2_resp;
    d_mem_resp  = (state == SERVE_D) & l2_resp;
    i_mem_rdata = l2_rdata;
    d_mem_rdata = l2_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of ownership, fair tie-breaking and the registered L2 request.
module tb_cache_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] i_mem_rdata, d_mem_rdata, l2_wdata;
  logic [LINE_W-1:0] l2_rdata = '0;
  logic              i_mem_resp, d_mem_resp, l2_read, l2_write;
  logic              l2_resp = 1'b0;
  logic [ADDR_W-1:0] l2_address;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_rd), .i_mem_address(i_addr), .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_address(d_addr), .d_mem_wdata(d_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: who owns the L2 port (0 none, 1 I, 2 D) and what the L2 must see
  int                owner = 0, last = 1;
  logic              m_read = 1'b0, m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  int                grants[$];
  int                lat = -1, lat_fixed = -1;
  int                i_resps = 0, d_resps = 0;
  bit                i_got = 0, d_got = 0, hold = 0, rnd = 0, use_fixed = 0;
  logic [LINE_W-1:0] fixed_data = '0;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    int pick;
    #1;
    assert (!(d_rd && d_wr)) else $error("illegal D read+write stimulus");
    check("i_resp", i_mem_resp, owner == 1 && l2_resp);
    check("d_resp", d_mem_resp, owner == 2 && l2_resp);
    if (owner == 1 && l2_resp) begin check("i_rdata", i_mem_rdata, l2_rdata); i_got = 1; i_resps++; end
    if (owner == 2 && l2_resp) begin check("d_rdata", d_mem_rdata, l2_rdata); d_got = 1; d_resps++; end
    @(posedge clk); #1;
    if (reset) begin
      owner = 0; last = 1; m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
    end else if (owner == 0) begin
      pick = 0;
      if ((d_rd || d_wr) && i_rd) pick = (last == 2) ? 1 : 2;
      else if (d_rd || d_wr)      pick = 2;
      else if (i_rd)              pick = 1;
      if (pick != 0) begin
        owner = pick; last = pick; grants.push_back(pick);
        lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
        m_addr  = (pick == 1) ? i_addr : d_addr;
        m_write = (pick == 2) && d_wr;
        m_read  = !m_write;
        if (pick == 2) m_wdata = d_wdata;
      end
    end else if (l2_resp) begin
      owner = 0; m_read = 0; m_write = 0;
    end
    check("l2_read", l2_read, m_read);
    check("l2_write", l2_write, m_write);
    check("l2_address", l2_address, m_addr);
    check("l2_wdata", l2_wdata, m_wdata);
  endtask

  task automatic drive_l2();
    l2_resp = 0;
    if (reset) return;
    if (owner != 0) begin
      if (lat == 0) begin
        l2_resp  = 1;
        l2_rdata = use_fixed ? fixed_data : rand_line();
        lat = -1;
      end else if (lat > 0) lat--;
    end else if (rnd && $urandom_range(0, 9) == 0) begin
      l2_resp  = 1;
      l2_rdata = rand_line();
    end
  endtask

  task automatic rand_stim();
    reset = ($urandom_range(0, 199) == 0);
    if (!i_rd && $urandom_range(0, 2) == 0) begin i_rd = 1; i_addr = ADDR_W'($urandom); end
    if (!d_rd && !d_wr && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 1) == 1) d_wr = 1; else d_rd = 1;
      d_addr = ADDR_W'($urandom); d_wdata = rand_line();
    end
    if (owner == 1 && i_rd && $urandom_range(0, 24) == 0) i_rd = 0;
    if (owner == 2 && (d_rd || d_wr) && $urandom_range(0, 24) == 0) begin d_rd = 0; d_wr = 0; end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (i_got) begin if (!hold) i_rd = 0; i_got = 0; end
      if (d_got) begin if (!hold) begin d_rd = 0; d_wr = 0; end d_got = 0; end
      if (rnd) rand_stim();
      drive_l2();
      step();
    end
  endtask

  task automatic do_reset();
    i_rd = 0; d_rd = 0; d_wr = 0; i_got = 0; d_got = 0;
    reset = 1; run_cycles(2); reset = 0;
    grants.delete();
  endtask

  int i0, d0;

  initial begin
    // 1: reset and idle
    do_reset();
    run_cycles(10);
    check("t1_grants", grants.size(), 0);

    // 2: I-cache read, L2 answers after 5 cycles
    use_fixed = 1; fixed_data = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    lat_fixed = 5; i0 = i_resps; d0 = d_resps;
    i_rd = 1; i_addr = 16'h1230;
    run_cycles(1);
    check("t2_l2_read", l2_read, 1);
    check("t2_addr", l2_address, 16'h1230);
    run_cycles(10);
    check("t2_i_count", i_resps - i0, 1);
    check("t2_d_count", d_resps - d0, 0);

    // 3: D-cache writeback
    lat_fixed = 3; i0 = i_resps; d0 = d_resps;
    d_wr = 1; d_addr = 16'h4560; d_wdata = {4{32'hA5A5A5A5}};
    run_cycles(1);
    check("t3_l2_write", l2_write, 1);
    check("t3_l2_read", l2_read, 0);
    check("t3_wdata", l2_wdata, {4{32'hA5A5A5A5}});
    run_cycles(8);
    check("t3_d_count", d_resps - d0, 1);
    check("t3_i_count", i_resps - i0, 0);

    // 4: simultaneous requests after reset, then held requests alternate
    do_reset();
    lat_fixed = 2;
    i_rd = 1; i_addr = 16'h0100; d_rd = 1; d_addr = 16'h0200;
    run_cycles(14);
    check("t4_n", grants.size(), 2);
    if (grants.size() >= 2) begin check("t4_g0", grants[0], 2); check("t4_g1", grants[1], 1); end
    do_reset();
    hold = 1; i_rd = 1; d_rd = 1;
    run_cycles(30);
    hold = 0; i_rd = 0; d_rd = 0;
    run_cycles(6);
    check("t4_hold_n", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      check("t4_h0", grants[0], 2); check("t4_h1", grants[1], 1);
      check("t4_h2", grants[2], 2); check("t4_h3", grants[3], 1);
    end

    // 5: D request arriving during SERVE_I waits for the I response
    do_reset();
    lat_fixed = 6;
    i_rd = 1; i_addr = 16'h1000;
    run_cycles(2);
    d_rd = 1; d_addr = 16'h2000;
    run_cycles(3);
    check("t5_addr_held", l2_address, 16'h1000);
    run_cycles(15);
    check("t5_n", grants.size(), 2);
    if (grants.size() >= 2) begin check("t5_g0", grants[0], 1); check("t5_g1", grants[1], 2); end

    // 6: reset two cycles into SERVE_D
    do_reset();
    lat_fixed = 10; d0 = d_resps; i0 = i_resps;
    d_rd = 1; d_addr = 16'h3000;
    run_cycles(3);
    reset = 1; run_cycles(1); reset = 0; d_rd = 0;
    check("t6_read_clr", l2_read, 0);
    lat_fixed = 2; i_rd = 1; i_addr = 16'h7770;
    run_cycles(1);
    check("t6_i_addr", l2_address, 16'h7770);
    run_cycles(6);
    check("t6_d_count", d_resps - d0, 0);
    check("t6_i_count", i_resps - i0, 1);

    // Randomized traffic with spurious L2 responses, request drops and resets
    do_reset();
    use_fixed = 0; lat_fixed = -1; rnd = 1;
    i0 = i_resps; d0 = d_resps;
    run_cycles(3000);
    rnd = 0; reset = 0;
    check("rand_progress", (i_resps - i0) > 20 && (d_resps - d0) > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
